// File: rtl/jt49_sdm_dac.sv
// jt49_sdm_dac: output stage of the JT49 audio path.
// Turns a signed, DC-free sample back into an unsigned level and drives a
// first-order sigma-delta bitstream. The mid-scale offset is brought in and
// out through a slow ramp, so power-up, mute and unmute produce no pop.
module jt49_sdm_dac #(
  parameter int DW       = 8,
  parameter int RAMP_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [DW-1:0] din,
  input  logic          mute,
  output logic [DW-1:0] level,
  output logic          ready,
  output logic          dout
);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // A one-step prescaler still needs a 1-bit counter to stay well formed.
  localparam int            CW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RAMP_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [DW-1:0] OFF_MID = DW'(32'd1 << (DW - 1));
  localparam logic [DW-1:0] OFF_ONE = DW'(32'd1);

  state_t          state_r, state_s;
  logic [DW-1:0]   off_r, off_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]   acc_r;
  logic [DW-1:0]   level_s;
  logic [DW:0]     sum_s;
  logic            step_s;

  // Ramp FSM: next state, offset and prescaler count.
  always_comb begin
    state_s = state_r;
    off_s   = off_r;
    cnt_s   = cnt_r;
    step_s  = (cnt_r == CNT_MAX);
    case (state_r)
      MUTED: begin
        off_s = '0;
        cnt_s = '0;
        if (!mute) state_s = RAMP_UP;
        else       state_s = MUTED;
      end
      RAMP_UP: begin
        if (mute) begin
          // Reverse direction without touching the offset.
          state_s = RAMP_DOWN;
          cnt_s   = '0;
        end else if (off_r == OFF_MID) begin
          // Already at mid-scale (unmute right at the top of a ramp-down).
          state_s = RUN;
          cnt_s   = '0;
        end else if (step_s) begin
          cnt_s = '0;
          off_s = off_r + OFF_ONE;
          if (off_s == OFF_MID) state_s = RUN;
          else                  state_s = RAMP_UP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        off_s = OFF_MID;
        cnt_s = '0;
        if (mute) state_s = RAMP_DOWN;
        else      state_s = RUN;
      end
      RAMP_DOWN: begin
        if (!mute) begin
          // Resume rising from wherever the offset is now.
          state_s = RAMP_UP;
          cnt_s   = '0;
        end else if (off_r == '0) begin
          // Muted right at the bottom of a ramp-up: nothing left to remove.
          state_s = MUTED;
          cnt_s   = '0;
        end else if (step_s) begin
          cnt_s = '0;
          off_s = off_r - OFF_ONE;
          if (off_s == '0) state_s = MUTED;
          else             state_s = RAMP_DOWN;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = MUTED;
        off_s   = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // Level source: audio with MSB flipped in RUN, ramp offset otherwise.
  always_comb begin
    level_s = off_r;
    if (state_r == RUN) level_s = {~din[DW-1], din[DW-2:0]};
    else                level_s = off_r;
  end

  // Modulator adder: the carry out of acc+level is the next output bit.
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, level};
  end

  // State, level and modulator registers; everything advances only on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MUTED;
      off_r   <= '0;
      cnt_r   <= '0;
      acc_r   <= '0;
      level   <= '0;
      ready   <= 1'b0;
      dout    <= 1'b0;
    end else if (cen) begin
      state_r <= state_s;
      off_r   <= off_s;
      cnt_r   <= cnt_s;
      level   <= level_s;
      ready   <= (state_s == RUN);
      acc_r   <= sum_s[DW-1:0];
      dout    <= sum_s[DW];
    end
  end

endmodule

// File: tb/tb_jt49_sdm_dac.sv
// Directed bench for jt49_sdm_dac with default parameters (DW=8, RAMP_DIV=4).
module tb_jt49_sdm_dac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       mute;
  logic [7:0] din;
  logic [7:0] level;
  logic       ready;
  logic       dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jt49_sdm_dac #(.DW(8), .RAMP_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .din   (din),
    .mute  (mute),
    .level (level),
    .ready (ready),
    .dout  (dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Level seen after the n-th cen of a ramp-up that starts in MUTED with off=0.
  function automatic int up_lvl(input int n);
    return (n <= 1) ? 0 : (n - 2) / 4;
  endfunction

  task automatic density(input logic [7:0] d, input int exp_ones, input string tag);
    int ones;
    din = d;
    tick();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      ones += int'(dout);
    end
    chk(tag, ones, exp_ones);
  endtask

  initial begin
    int         n;
    int         cyc;
    logic [7:0] pl;
    logic       pr;
    logic       pd;
    logic [7:0] vin [4];
    int         vexp [4];

    rst_n = 1'b0;
    cen   = 1'b1;
    mute  = 1'b0;
    din   = 8'd0;
    #12;
    chk("rst_level", level, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ready", ready, 0);
    #5;
    rst_n = 1'b1;

    // Power-up ramp: level 0 -> 127 in RAMP_UP, ready after cen 513.
    for (int k = 1; k <= 513; k++) begin
      tick();
      chk("p1_level", level, up_lvl(k));
      chk("p1_ready", ready, (k >= 513) ? 1 : 0);
      if (k <= 6) chk("p1_dout", dout, 0);
    end

    // RUN pass-through: MSB flip, one cen latency.
    vin[0] = 8'h80; vexp[0] = 0;
    vin[1] = 8'hFF; vexp[1] = 127;
    vin[2] = 8'h00; vexp[2] = 128;
    vin[3] = 8'h7F; vexp[3] = 255;
    for (int i = 0; i < 4; i++) begin
      din = vin[i];
      tick();
      chk("p2_level", level, vexp[i]);
    end

    // Bitstream density over 256 cens.
    density(8'hC0, 64, "p3_ones_64");
    density(8'h80, 0, "p3_ones_0");
    density(8'h7F, 255, "p3_ones_255");

    // Mute from RUN: full ramp down 128 -> 0, then hold at 0.
    din  = 8'h00;
    mute = 1'b1;
    tick();
    chk("p4_ready", ready, 0);
    chk("p4_level_first", level, 128);
    for (int k = 2; k <= 513; k++) begin
      tick();
      chk("p4_level", level, 128 - (k - 2) / 4);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("p4_muted_level", level, 0);
      chk("p4_muted_ready", ready, 0);
      if (j >= 2) chk("p4_muted_dout", dout, 0);
    end

    // Unmute with cen one cycle in three: ramp stretches 3x, state frozen between.
    mute = 1'b0;
    n    = 0;
    cyc  = 0;
    pl   = level;
    pr   = ready;
    pd   = dout;
    while (n < 513 && cyc < 3000) begin
      cen = (cyc % 3 == 0);
      tick();
      cyc++;
      if (cen) begin
        n++;
        chk("p5_level", level, up_lvl(n));
        chk("p5_ready", ready, (n >= 513) ? 1 : 0);
      end else begin
        chk("p5_hold_level", level, pl);
        chk("p5_hold_ready", ready, pr);
        chk("p5_hold_dout", dout, pd);
      end
      pl = level;
      pr = ready;
      pd = dout;
    end
    chk("p5_cycles", cyc, 1537);
    cen = 1'b1;

    // Mute, then unmute once off has come down to 50: no jump in level.
    mute = 1'b1;
    for (int k = 1; k <= 313; k++) begin
      tick();
      chk("p6_down_level", level, (k == 1) ? 128 : 128 - (k - 2) / 4);
    end
    mute = 1'b0;
    for (int k = 1; k <= 313; k++) begin
      tick();
      chk("p6_up_level", level, (k == 1) ? 50 : 50 + (k - 2) / 4);
      chk("p6_up_ready", ready, (k >= 313) ? 1 : 0);
    end

    // Asynchronous reset between clock edges while in RUN.
    din = 8'h7F;
    tick();
    chk("p7_level_run", level, 255);
    for (int i = 0; i < 4 && dout !== 1'b1; i++) tick();
    chk("p7_dout_pre", dout, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p7_rst_level", level, 0);
    chk("p7_rst_dout", dout, 0);
    chk("p7_rst_ready", ready, 0);
    tick();
    chk("p7_rst_hold_level", level, 0);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("p7_restart_level", level, up_lvl(k));
      chk("p7_restart_ready", ready, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt49_sdm_dac.md
Name: jt49_sdm_dac

Overview:
- Output end of the JT49 audio path: the DC removal filter turns unsigned PSG level into signed audio; this block turns signed audio back into unsigned level and drives a 1-bit first-order sigma-delta DAC pin.
- Reinserts the mid-scale offset through a soft ramp so power-up, mute and unmute produce no pop.
- Sits between the filtered signed sample and the FPGA output pin.

Parameters:
- DW, 8, sample width in bits (signed input, unsigned level); legal range 4..16.
- RAMP_DIV, 4, number of cen pulses per 1-LSB offset step; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cen  input  1  clock enable; all state advances only on cycles with cen=1.
- din  input  DW  signed audio sample; sampled on cen.
- mute  input  1  level-sensitive request to ramp the output down to 0 and hold it there.
- level  output  DW  registered unsigned level presently fed to the modulator.
- ready  output  1  high only in RUN, when din passes through.
- dout  output  1  registered sigma-delta bitstream.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=MUTED, off=0, cnt=0, acc=0.
  - level=0, dout=0, ready=0.
- Internal registers:
  - off: unsigned DW-1+1 bits, range 0..2^(DW-1).
  - cnt: prescaler, 0..RAMP_DIV-1.
  - acc: DW bits.
- States: MUTED, RAMP_UP, RUN, RAMP_DOWN. Transitions are evaluated only on cen.
- MUTED:
  - off=0, cnt held at 0.
  - mute=0 → RAMP_UP.
- RAMP_UP:
  - cnt increments each cen; on cnt==RAMP_DIV-1, cnt←0 and off←off+1.
  - On the cen that writes off=2^(DW-1) → RUN.
  - mute=1 → RAMP_DOWN immediately: cnt←0, off unchanged on that cen.
- RUN:
  - off stays at 2^(DW-1).
  - mute=1 → RAMP_DOWN with cnt←0.
- RAMP_DOWN:
  - Same prescaler as RAMP_UP; off←off−1 per step.
  - On the cen that writes off=0 → MUTED.
  - mute=0 → RAMP_UP with cnt←0, continuing from the current off (no jump).
- level update, on each cen:
  - In RUN: level←din+2^(DW-1), i.e. din with its MSB inverted. This never overflows; no clipping is required.
  - In all other states: level←off, truncated to DW bits. The 2^(DW-1) value fits in DW bits. din is ignored outside RUN.
- Modulator, on each cen, using the previous level value:
  - {carry, acc}←acc+level, computed at DW+1 bits.
  - dout←carry.
  - Mean of dout over 2^DW cens equals level/2^DW exactly.
  - level=0 gives constant 0; level=2^DW−1 gives 1 on all but one cen in 2^DW.
- ready is registered and is 1 exactly in the cycles following entry to RUN. It drops on the same cen that leaves RUN.
- Latency: din→level 1 cen; level→dout 1 cen.
- With cen=0 every register holds, including during a ramp.
- Full ramp length: 2^(DW-1)·RAMP_DIV cens. With defaults, 512 cens.
- An asynchronous reset at any point returns to MUTED/off=0 regardless of state. After release, if mute=0, RAMP_UP starts on the first cen.

Test Plan:
- Reset release with mute=0, cen always 1, defaults:
  - state goes MUTED→RAMP_UP on the 1st cen.
  - level climbs 0→128 in steps of 1 every 4 cens.
  - ready rises after cen 513 (±1 for the MUTED cycle, checked exactly against the FSM).
- RUN with din = −128, −1, 0, 127 → level = 0, 127, 128, 255 exactly one cen later.
- RUN, level held at 64 for 256 cens → exactly 64 ones on dout; level 0 → all zeros.
- mute asserted in RUN → ready falls, level 128→0 over 512 cens, state MUTED. Deasserting mute at off=50 mid-RAMP_DOWN → level resumes rising from 50, with no discontinuity greater than 1 LSB.
- cen toggled 1-in-3 during RAMP_UP → ramp takes 3× the cycles; all registers frozen on cen=0 cycles.
- rst_n pulsed low asynchronously mid-RUN, between clock edges → level=0, dout=0, ready=0 immediately; ramp restarts from 0.
